// File: rtl/phy_fault_pkg.sv
// rtl/phy_fault_pkg.sv - shared constants, lane states and 8b/10b disparity helpers for phy_tx_fault_inject
package phy_fault_pkg;

  localparam logic [1:0] c_MODE_PASS    = 2'b00;
  localparam logic [1:0] c_MODE_IDLE    = 2'b01;
  localparam logic [1:0] c_MODE_KILL    = 2'b10;
  localparam logic [1:0] c_MODE_CORRUPT = 2'b11;

  localparam logic [15:0] c_IDLE_DATA16 = 16'hBC50;
  localparam logic [1:0]  c_IDLE_K16    = 2'b10;
  localparam logic [7:0]  c_IDLE8_COMMA = 8'hBC;
  localparam logic [7:0]  c_IDLE8_DATA  = 8'h50;

  // Tables are indexed MSB-first: entry 0 lives in the top bit.
  localparam logic [31:0] c_DP6 = 32'hE8818197;
  localparam logic [7:0]  c_DP4 = 8'h89;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_KILL    = 2'd1,
    ST_CORRUPT = 2'd2
  } lane_state_e;

  function automatic logic f_next_disp8(input logic disp, input logic [7:0] d, input logic k);
    if (k && (d[1:0] != 2'b00))
      return disp;
    return disp ^ (k ^ c_DP6[5'd31 - d[4:0]] ^ c_DP4[3'd7 - d[7:5]]);
  endfunction

  function automatic logic f_next_disp16(input logic disp, input logic [15:0] d, input logic [1:0] k);
    return f_next_disp8(f_next_disp8(disp, d[15:8], k[1]), d[7:0], k[0]);
  endfunction

endpackage

// File: rtl/phy_fault_lane.sv
// rtl/phy_fault_lane.sv - one lane: burst FSM, output mux, 8-bit idle phase and running disparity
module phy_fault_lane
  import phy_fault_pkg::*;
#(
  parameter int          g_pcs_16bit = 1,
  parameter int          g_cnt_width = 16,
  parameter logic [15:0] g_idle_data = c_IDLE_DATA16,
  parameter logic [1:0]  g_idle_k    = c_IDLE_K16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            tx_data,
  input  logic [1:0]             tx_k,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic [g_cnt_width-1:0] burst_len,
  output logic [15:0]            data_out,
  output logic [1:0]             k_out,
  output logic                   disparity,
  output logic                   enc_err,
  output logic                   busy
);

  lane_state_e            state_q, state_d;
  logic [g_cnt_width-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [15:0]            data_d;
  logic [1:0]             k_d;
  logic                   err_d;
  logic                   disp_d;
  logic                   sel_idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_PASS: begin
        if (start && (burst_len != '0)) begin
          if (mode == c_MODE_KILL) begin
            state_d = ST_KILL;
            cnt_d   = burst_len - 1'b1;
          end else if (mode == c_MODE_CORRUPT) begin
            state_d = ST_CORRUPT;
            cnt_d   = burst_len - 1'b1;
          end
        end
      end
      ST_KILL, ST_CORRUPT: begin
        if (cnt_q == '0)
          state_d = ST_PASS;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_PASS;
        cnt_d   = '0;
      end
    endcase
  end

  // The mux looks at the next state so the first burst word leaves on the start edge.
  always_comb begin
    data_d   = 16'h0000;
    k_d      = 2'b00;
    err_d    = 1'b0;
    sel_idle = 1'b0;
    if (state_d == ST_CORRUPT) begin
      err_d = 1'b1;
      if (g_pcs_16bit != 0) begin
        data_d = 16'hFFFF;
        k_d    = 2'b11;
      end else begin
        data_d = 16'h00FF;
        k_d    = 2'b01;
      end
    end else if ((state_d == ST_KILL) || (mode == c_MODE_IDLE)) begin
      sel_idle = 1'b1;
      if (g_pcs_16bit != 0) begin
        data_d = g_idle_data;
        k_d    = g_idle_k;
      end else if (phase_q) begin
        data_d = {8'h00, c_IDLE8_DATA};
        k_d    = 2'b00;
      end else begin
        data_d = {8'h00, c_IDLE8_COMMA};
        k_d    = 2'b01;
      end
    end else if (g_pcs_16bit != 0) begin
      data_d = tx_data;
      k_d    = tx_k;
    end else begin
      data_d = {8'h00, tx_data[7:0]};
      k_d    = {1'b0, tx_k[0]};
    end
    phase_d = sel_idle ? ~phase_q : 1'b0;
  end

  // Disparity tracks the word already on the wire; corrupt words leave it alone.
  always_comb begin
    disp_d = disparity;
    if (!enc_err) begin
      if (g_pcs_16bit != 0)
        disp_d = f_next_disp16(disparity, data_out, k_out);
      else
        disp_d = f_next_disp8(disparity, data_out[7:0], k_out[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PASS;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      data_out  <= 16'h0000;
      k_out     <= 2'b00;
      enc_err   <= 1'b0;
      busy      <= 1'b0;
      disparity <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      data_out  <= data_d;
      k_out     <= k_d;
      enc_err   <= err_d;
      busy      <= (state_d != ST_PASS);
      disparity <= disp_d;
    end
  end

endmodule

// File: rtl/phy_tx_fault_inject.sv
// rtl/phy_tx_fault_inject.sv - multi-lane TX fault injector between endpoint PCS and PHY
module phy_tx_fault_inject
  import phy_fault_pkg::*;
#(
  parameter int          g_num_ports = 6,
  parameter int          g_pcs_16bit = 1,
  parameter int          g_cnt_width = 16,
  parameter logic [15:0] g_idle_data = 16'hBC50,
  parameter logic [1:0]  g_idle_k    = 2'b10
) (
  input  logic                    clk_ref_i,
  input  logic                    rst_i,
  input  logic [16*g_num_ports-1:0] tx_data_i,
  input  logic [2*g_num_ports-1:0]  tx_k_i,
  input  logic [2*g_num_ports-1:0]  mode_i,
  input  logic [g_num_ports-1:0]    start_i,
  input  logic [g_cnt_width-1:0]    burst_len_i,
  output logic [16*g_num_ports-1:0] tx_data_o,
  output logic [2*g_num_ports-1:0]  tx_k_o,
  output logic [g_num_ports-1:0]    tx_disparity_o,
  output logic [g_num_ports-1:0]    tx_enc_err_o,
  output logic [g_num_ports-1:0]    busy_o
);

  for (genvar j = 0; j < g_num_ports; j++) begin : g_lane
    phy_fault_lane #(
      .g_pcs_16bit (g_pcs_16bit),
      .g_cnt_width (g_cnt_width),
      .g_idle_data (g_idle_data),
      .g_idle_k    (g_idle_k)
    ) u_lane (
      .clk       (clk_ref_i),
      .rst       (rst_i),
      .tx_data   (tx_data_i[16*j +: 16]),
      .tx_k      (tx_k_i[2*j +: 2]),
      .mode      (mode_i[2*j +: 2]),
      .start     (start_i[j]),
      .burst_len (burst_len_i),
      .data_out  (tx_data_o[16*j +: 16]),
      .k_out     (tx_k_o[2*j +: 2]),
      .disparity (tx_disparity_o[j]),
      .enc_err   (tx_enc_err_o[j]),
      .busy      (busy_o[j])
    );
  end

endmodule

// File: tb/tb_phy_tx_fault_inject.sv
// tb/tb_phy_tx_fault_inject.sv - directed self-checking bench for phy_tx_fault_inject (16-bit and 8-bit builds)
module tb_phy_tx_fault_inject;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] tx_data;
  logic [11:0] tx_k;
  logic [11:0] mode;
  logic [5:0]  start;
  logic [15:0] burst_len;
  logic [95:0] data_o;
  logic [11:0] k_o;
  logic [5:0]  disp_o;
  logic [5:0]  err_o;
  logic [5:0]  busy_o;

  logic [15:0] d8_data;
  logic [1:0]  d8_k;
  logic [1:0]  d8_mode;
  logic        d8_start;
  logic [15:0] d8_data_o;
  logic [1:0]  d8_k_o;
  logic        d8_disp_o;
  logic        d8_err_o;
  logic        d8_busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phy_tx_fault_inject dut (
    .clk_ref_i      (clk),
    .rst_i          (rst),
    .tx_data_i      (tx_data),
    .tx_k_i         (tx_k),
    .mode_i         (mode),
    .start_i        (start),
    .burst_len_i    (burst_len),
    .tx_data_o      (data_o),
    .tx_k_o         (k_o),
    .tx_disparity_o (disp_o),
    .tx_enc_err_o   (err_o),
    .busy_o         (busy_o)
  );

  phy_tx_fault_inject #(.g_num_ports(1), .g_pcs_16bit(0)) dut8 (
    .clk_ref_i      (clk),
    .rst_i          (rst),
    .tx_data_i      (d8_data),
    .tx_k_i         (d8_k),
    .mode_i         (d8_mode),
    .start_i        (d8_start),
    .burst_len_i    (burst_len),
    .tx_data_o      (d8_data_o),
    .tx_k_o         (d8_k_o),
    .tx_disparity_o (d8_disp_o),
    .tx_enc_err_o   (d8_err_o),
    .busy_o         (d8_busy_o)
  );

  function automatic logic [15:0] ld(input int j);
    return data_o[16*j +: 16];
  endfunction

  function automatic logic [1:0] lk(input int j);
    return k_o[2*j +: 2];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({data_o, k_o, disp_o, err_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset16 got data=%h k=%h disp=%b err=%b busy=%b want all 0", data_o, k_o, disp_o, err_o, busy_o);
    end
    checks++;
    if ({d8_data_o, d8_k_o, d8_disp_o, d8_err_o, d8_busy_o} !== '0) begin
      errors++;
      $display("FAIL reset8 got data=%h k=%h want 0", d8_data_o, d8_k_o);
    end
  endtask

  task automatic test_pass();
    logic exp_disp [3] = '{1'b0, 1'b1, 1'b0};
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ld(0) !== 16'h1234 || lk(0) !== 2'b00 || err_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL pass_lane0 cyc%0d got %h/%b err=%b want 1234/00 err=0", i, ld(0), lk(0), err_o[0]);
      end
      checks++;
      if (disp_o[0] !== exp_disp[i]) begin
        errors++;
        $display("FAIL pass_disp cyc%0d got %b want %b", i, disp_o[0], exp_disp[i]);
      end
      checks++;
      if (d8_data_o !== 16'h0034 || d8_k_o !== 2'b01) begin
        errors++;
        $display("FAIL pass8 cyc%0d got %h/%b want 0034/01", i, d8_data_o, d8_k_o);
      end
    end
  endtask

  task automatic test_idle_disp();
    mode[9:8] = 2'b10;
    start[4]  = 1'b1;
    burst_len = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start[4] = 1'b0;
      checks++;
      if (ld(3) !== 16'hBC50 || lk(3) !== 2'b10 || disp_o[3] !== 1'b0) begin
        errors++;
        $display("FAIL idle16 cyc%0d got %h/%b disp=%b want bc50/10 disp=0", i, ld(3), lk(3), disp_o[3]);
      end
      checks++;
      if (ld(4) !== 16'h5555 || busy_o[4] !== 1'b0) begin
        errors++;
        $display("FAIL len0_start cyc%0d got %h busy=%b want 5555 busy=0", i, ld(4), busy_o[4]);
      end
    end
  endtask

  task automatic test_kill();
    mode[5:4] = 2'b10;
    start[2]  = 1'b1;
    burst_len = 16'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start[2] = 1'b0;
      checks++;
      if (ld(2) !== 16'hBC50 || lk(2) !== 2'b10 || busy_o[2] !== 1'b1 || err_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL kill_burst cyc%0d got %h/%b busy=%b err=%b want bc50/10 busy=1 err=0", i, ld(2), lk(2), busy_o[2], err_o[2]);
      end
      checks++;
      if (ld(0) !== 16'h1234 || busy_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL kill_isolation cyc%0d got %h busy=%b want 1234 busy=0", i, ld(0), busy_o[0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ld(2) !== 16'hA5A5 || lk(2) !== 2'b00 || busy_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL kill_end cyc%0d got %h/%b busy=%b want a5a5/00 busy=0", i, ld(2), lk(2), busy_o[2]);
      end
    end
  endtask

  task automatic test_corrupt();
    logic exp_disp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_cor  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tx_data[31:16] = 16'h1234;
    mode[3:2]      = 2'b11;
    burst_len      = 16'd3;
    for (int i = 0; i < 8; i++) begin
      start[1] = (i == 3) || (i == 4);
      @(negedge clk);
      checks++;
      if (exp_cor[i]) begin
        if (ld(1) !== 16'hFFFF || lk(1) !== 2'b11 || err_o[1] !== 1'b1 || busy_o[1] !== 1'b1) begin
          errors++;
          $display("FAIL corrupt_word cyc%0d got %h/%b err=%b busy=%b want ffff/11 err=1 busy=1", i, ld(1), lk(1), err_o[1], busy_o[1]);
        end
      end else begin
        if (ld(1) !== 16'h1234 || lk(1) !== 2'b00 || err_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
          errors++;
          $display("FAIL corrupt_pass cyc%0d got %h/%b err=%b busy=%b want 1234/00 err=0 busy=0", i, ld(1), lk(1), err_o[1], busy_o[1]);
        end
      end
      checks++;
      if (disp_o[1] !== exp_disp[i]) begin
        errors++;
        $display("FAIL corrupt_disp cyc%0d got %b want %b", i, disp_o[1], exp_disp[i]);
      end
    end
    start[1] = 1'b0;
  endtask

  task automatic test_idle8();
    logic [1:0]  seq_mode [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    logic [15:0] exp_data [7] = '{16'h00BC, 16'h0050, 16'h00BC, 16'h0050, 16'h0034, 16'h00BC, 16'h0050};
    logic [1:0]  exp_k    [7] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 7; i++) begin
      d8_mode = seq_mode[i];
      @(negedge clk);
      checks++;
      if (d8_data_o !== exp_data[i] || d8_k_o !== exp_k[i] || d8_err_o !== 1'b0) begin
        errors++;
        $display("FAIL idle8 cyc%0d got %h/%b err=%b want %h/%b err=0", i, d8_data_o, d8_k_o, d8_err_o, exp_data[i], exp_k[i]);
      end
    end
    d8_mode = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    mode[11:10]    = 2'b10;
    tx_data[95:80] = 16'h0F0F;
    burst_len      = 16'd10;
    start[5]       = 1'b1;
    @(negedge clk);
    start[5] = 1'b0;
    checks++;
    if (busy_o[5] !== 1'b1 || ld(5) !== 16'hBC50) begin
      errors++;
      $display("FAIL rst_burst_start got %h busy=%b want bc50 busy=1", ld(5), busy_o[5]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_o, k_o, disp_o, err_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_burst got data=%h k=%h busy=%b want all 0", data_o, k_o, busy_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ld(5) !== 16'h0F0F || lk(5) !== 2'b00 || busy_o[5] !== 1'b0) begin
        errors++;
        $display("FAIL rst_then_pass cyc%0d got %h/%b busy=%b want 0f0f/00 busy=0", i, ld(5), lk(5), busy_o[5]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    tx_data   = '0;
    tx_k      = '0;
    mode      = '0;
    start     = '0;
    burst_len = '0;
    d8_data   = 16'h1234;
    d8_k      = 2'b11;
    d8_mode   = 2'b00;
    d8_start  = 1'b0;
    tx_data[15:0]  = 16'h1234;
    tx_data[47:32] = 16'hA5A5;
    tx_data[79:64] = 16'h5555;
    mode[7:6]      = 2'b01;
    test_reset();
    test_pass();
    test_idle_disp();
    test_kill();
    test_corrupt();
    test_idle8();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
